gpio_irq_port: RTL

GPIO_IRQ_PORT -- requirements
Module: gpio_irq_port

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_debounce.sv | 42 ++++
 rtl/gpio_irq_port.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared definitions for the gpio_irq_port block.
//
// Holds the register byte offsets, the bus handshake state encoding and a
// small helper that expands byte strobes into a 32-bit bit mask.
// Optional feature macro used by this block: GPIO_DEBOUNCE_EN (see top).

package gpio_pkg;

  // Register byte offsets within the 32-byte window
  localparam logic [4:0] GPIO_OUT  = 5'h00;
  localparam logic [4:0] GPIO_IN   = 5'h04;
  localparam logic [4:0] GPIO_IEN  = 5'h08;
  localparam logic [4:0] GPIO_EDGE = 5'h0C;
  localparam logic [4:0] GPIO_PEND = 5'h10;

  // Bus handshake states
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  // Turns the four byte enables into a per-bit write mask
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce -- single-bit stability filter.
//
// The output follows the input only after the input has disagreed with the
// current output for DEB_CYCLES consecutive clock samples. Any sample that
// agrees with the output restarts the count.
//
// Ports:
//   clk     input   clock
//   resetn  input   asynchronous active-low reset (output and count to 0)
//   din     input   already-synchronized sample
//   dout    output  filtered value

module gpio_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] run_cnt;

  // Count consecutive samples that differ from the held value; flip the
  // held value on the DEB_CYCLES-th such sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cnt <= '0;
      dout    <= 1'b0;
    end else if (din == dout) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(DEB_CYCLES - 1)) begin
      run_cnt <= '0;
      dout    <= din;
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gpio_irq_port.sv
// gpio_irq_port -- memory-mapped GPIO port with edge-triggered interrupts.
//
// Registers (byte offsets): 0x00 OUT (RW), 0x04 IN (RO), 0x08 IEN (RW),
// 0x0C EDGE (RW, 1 = rising, 0 = falling), 0x10 PEND (RO, write-1-to-clear).
// Bits at and above WIDTH read as zero and ignore writes.
//
// Build option: define GPIO_DEBOUNCE_EN to insert a gpio_debounce filter per
// pin after the synchronizer; without it the synchronized value is used
// directly and DEB_CYCLES has no effect.
//
// Ports:
//   clk        input         clock
//   resetn     input         asynchronous active-low reset
//   mem_valid  input         bus request, held until mem_ready
//   mem_sel    input         address decode hit
//   mem_addr   input  [4:0]  byte offset, bits [1:0] ignored
//   mem_wdata  input  [31:0] write data
//   mem_wstrb  input  [3:0]  byte enables, zero means read
//   mem_rdata  output [31:0] read data, zero unless mem_ready
//   mem_ready  output        one-cycle acknowledge
//   port_in    input  [W-1:0] asynchronous pins
//   port_out   output [W-1:0] registered outputs
//   irq        output        level interrupt, |(PEND & IEN) registered

module gpio_irq_port #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic             mem_sel,
  input  logic [4:0]       mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] port_out,
  output logic             irq
);

  import gpio_pkg::*;

  if (WIDTH < 1 || WIDTH > 32 || DEB_CYCLES < 1) begin : g_bad_params
    $error("gpio_irq_port: WIDTH must be 1..32 and DEB_CYCLES at least 1");
  end

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] pin_filt;
  logic [WIDTH-1:0] pin_prev;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] pend_q;

  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] pend_clr;

  bus_state_t       bus_state;
  logic [4:0]       word_addr;
  logic             wr_en;
  logic [31:0]      wr_mask;
  logic [31:0]      wr_bits;
  logic [31:0]      rd_word;
  logic             bus_unused;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= port_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    gpio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .resetn(resetn),
      .din   (sync_q2[i]),
      .dout  (pin_filt[i])
    );
  end
`else
  assign pin_filt = sync_q2;
`endif

  // Synchronizer, filter and previous-value flops all reset to 0, so nothing
  // can look like an edge until real pin data has walked through them.
  assign edge_hit = (pin_filt & ~pin_prev &  edge_q)
                  | (~pin_filt & pin_prev & ~edge_q);

  assign word_addr  = {mem_addr[4:2], 2'b00};
  assign wr_en      = (bus_state == BUS_ACK) && (mem_wstrb != 4'b0000);
  assign wr_mask    = strb_to_mask(mem_wstrb);
  assign wr_bits    = mem_wdata & wr_mask;
  assign pend_clr   = (wr_en && word_addr == GPIO_PEND) ? wr_bits[WIDTH-1:0] : '0;
  assign bus_unused = ^{mem_addr[1:0], wr_mask, wr_bits};

  // Register file: CPU writes land on the acknowledge cycle. Pending bits
  // are set by detected edges, and a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      ien_q    <= '0;
      edge_q   <= '1;
      pend_q   <= '0;
      pin_prev <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (word_addr)
          GPIO_OUT:  out_q  <= (out_q  & ~wr_mask[WIDTH-1:0]) | wr_bits[WIDTH-1:0];
          GPIO_IEN:  ien_q  <= (ien_q  & ~wr_mask[WIDTH-1:0]) | wr_bits[WIDTH-1:0];
          GPIO_EDGE: edge_q <= (edge_q & ~wr_mask[WIDTH-1:0]) | wr_bits[WIDTH-1:0];
          default: ;
        endcase
      end
      pend_q   <= (pend_q & ~pend_clr) | edge_hit;
      pin_prev <= pin_filt;
      irq      <= |(pend_q & ien_q);
    end
  end

  // Read multiplexer, zero-extended; unmapped offsets return zero
  always_comb begin
    rd_word = '0;
    case (word_addr)
      GPIO_OUT:  rd_word[WIDTH-1:0] = out_q;
      GPIO_IN:   rd_word[WIDTH-1:0] = pin_filt;
      GPIO_IEN:  rd_word[WIDTH-1:0] = ien_q;
      GPIO_EDGE: rd_word[WIDTH-1:0] = edge_q;
      GPIO_PEND: rd_word[WIDTH-1:0] = pend_q;
      default: ;
    endcase
  end

  // Bus handshake: a request seen in IDLE is acknowledged in the following
  // cycle, with read data registered alongside mem_ready. Returning to IDLE
  // after every ack means a still-high mem_valid starts a fresh access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_state <= BUS_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (mem_valid && mem_sel) begin
            bus_state <= BUS_ACK;
            mem_ready <= 1'b1;
            mem_rdata <= rd_word;
          end else begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
          end
        end
        default: begin
          bus_state <= BUS_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= '0;
        end
      endcase
    end
  end

  assign port_out = out_q;

endmodule
